// File: rtl/gambit_rob_pkg.sv
// rtl/gambit_rob_pkg.sv - shared ROB pointer/count types and sizing constants
`include "Gambit-config.sv"

package gambit_rob_pkg;

    localparam int ROB_ENTRIES  = `RENTRIES;
    localparam int ROB_SLOTS    = `RSLOTS;
    localparam int ROB_BITS     = `RBITS;
    localparam int RETIRE_CNT_W = 40;

    // Entry index into the ring.
    typedef logic [`RBITS-1:0] rob_ptr_t;
    // Occupancy 0..RENTRIES needs one extra bit.
    typedef logic [`RBITS:0]   rob_cnt_t;
    // Headroom for count + acc - ret without overflow or underflow.
    typedef logic [`RBITS+1:0] rob_wide_t;

endpackage

// File: rtl/Gambit-config.sv
// rtl/Gambit-config.sv - reorder-buffer sizing macros shared by the ROB slice
`ifndef GAMBIT_CONFIG_SV
`define GAMBIT_CONFIG_SV

// RENTRIES : reorder-buffer entries (power of two, 8..32)
// RSLOTS   : enqueue slots per cycle (1..4)
// RBITS    : pointer width, log2(RENTRIES)
`define RENTRIES 16
`define RSLOTS   4
`define RBITS    4

`endif

// File: rtl/rob_ptr_add.sv
// rtl/rob_ptr_add.sv - modular ring-pointer advance
// Ports:
//   ptr  in   rob_ptr_t  current pointer
//   amt  in   4 bits     advance amount 0..15
//   sum  out  rob_ptr_t  (ptr + amt) mod RENTRIES
module rob_ptr_add
    import gambit_rob_pkg::*;
(
    input  rob_ptr_t   ptr,
    input  logic [3:0] amt,
    output rob_ptr_t   sum
);

    // RENTRIES is a power of two, so resizing amt to the pointer width
    // (truncating or zero-extending) and letting the add overflow gives
    // the wrap for free, including amounts larger than the ring.
    assign sum = ptr + rob_ptr_t'(amt);

endmodule

// File: rtl/rob_head_ctrl.sv
// rtl/rob_head_ctrl.sv - reorder-buffer head/tail/occupancy controller
// Optional feature macro: RETIRE_CNT_EN adds a 40-bit retired-entry counter.
// Ports:
//   rst_i          in   async active-high reset
//   clk_i          in   clock
//   commit_i       in   retire enable
//   r_amt          in   requested retire amount
//   queued_i       in   entries enqueued this cycle
//   flush_i        in   branch-miss flush
//   flush_tail_i   in   tail after flush
//   rob_heads      out  (head+i) mod RENTRIES, i = 0..RENTRIES-1
//   rob_tails      out  (tail+i) mod RENTRIES, i = 0..RSLOTS-1
//   count_o        out  occupied entries
//   full_o         out  count_o > RENTRIES-RSLOTS
//   empty_o        out  count_o == 0
//   retired_cnt_o  out  running total of retired entries (RETIRE_CNT_EN only)
module rob_head_ctrl
    import gambit_rob_pkg::*;
#(
    parameter int RENTRIES = `RENTRIES,
    parameter int RSLOTS   = `RSLOTS
) (
    input  logic       rst_i,
    input  logic       clk_i,
    input  logic       commit_i,
    input  logic [3:0] r_amt,
    input  logic [2:0] queued_i,
    input  logic       flush_i,
    input  rob_ptr_t   flush_tail_i,
    output rob_ptr_t   rob_heads [RENTRIES],
    output rob_ptr_t   rob_tails [RSLOTS],
    output rob_cnt_t   count_o,
    output logic       full_o,
    output logic       empty_o
`ifdef RETIRE_CNT_EN
    ,
    output logic [RETIRE_CNT_W-1:0] retired_cnt_o
`endif
);

    rob_wide_t cnt_w;
    rob_wide_t ret_w;
    rob_wide_t space_w;
    rob_wide_t acc_w;
    rob_ptr_t  head_next;
    rob_ptr_t  tail_adv;
    rob_ptr_t  tail_next;
    rob_ptr_t  flush_cnt;
    rob_cnt_t  count_next;

    always_comb begin
        cnt_w   = rob_wide_t'(count_o);
        ret_w   = '0;
        if (commit_i)
            ret_w = (rob_wide_t'(r_amt) < cnt_w) ? rob_wide_t'(r_amt) : cnt_w;
        // Entries freed by this cycle's retire are available to enqueue.
        space_w = rob_wide_t'(RENTRIES) - cnt_w + ret_w;
        acc_w   = (rob_wide_t'(queued_i) < space_w) ? rob_wide_t'(queued_i) : space_w;
    end

    // ret never exceeds r_amt (4 bits); acc never exceeds queued_i (3 bits).
    rob_ptr_add u_head_add (
        .ptr (rob_heads[0]),
        .amt (ret_w[3:0]),
        .sum (head_next)
    );

    rob_ptr_add u_tail_add (
        .ptr (rob_tails[0]),
        .amt ({1'b0, acc_w[2:0]}),
        .sum (tail_adv)
    );

    always_comb begin
        // After a flush the occupancy is the ring distance from the new head
        // to the new tail; equal pointers therefore mean empty, never full.
        flush_cnt  = flush_tail_i - head_next;
        tail_next  = tail_adv;
        count_next = rob_cnt_t'(cnt_w + acc_w - ret_w);
        if (flush_i) begin
            tail_next  = flush_tail_i;
            count_next = rob_cnt_t'(flush_cnt);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RENTRIES; i++) rob_heads[i] <= rob_ptr_t'(i);
            for (int i = 0; i < RSLOTS; i++)   rob_tails[i] <= rob_ptr_t'(i);
            count_o <= '0;
            full_o  <= 1'b0;
            empty_o <= 1'b1;
        end else begin
            for (int i = 0; i < RENTRIES; i++) rob_heads[i] <= head_next + rob_ptr_t'(i);
            for (int i = 0; i < RSLOTS; i++)   rob_tails[i] <= tail_next + rob_ptr_t'(i);
            count_o <= count_next;
            full_o  <= rob_wide_t'(count_next) > rob_wide_t'(RENTRIES - RSLOTS);
            empty_o <= (count_next == '0);
        end
    end

`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) retired_cnt_o <= '0;
        else       retired_cnt_o <= retired_cnt_o + RETIRE_CNT_W'(ret_w);
    end
`endif

endmodule

// File: tb/tb_rob_head_ctrl.sv
// tb/tb_rob_head_ctrl.sv - scoreboard bench for rob_head_ctrl
module tb_rob_head_ctrl;
    import gambit_rob_pkg::*;

    localparam int N = ROB_ENTRIES;
    localparam int S = ROB_SLOTS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       commit = 1'b0;
    logic [3:0] amt = '0;
    logic [2:0] queued = '0;
    logic       flush = 1'b0;
    rob_ptr_t   ft = '0;
    rob_ptr_t   heads [N];
    rob_ptr_t   tails [S];
    rob_cnt_t   cnt;
    logic       full;
    logic       empty;
`ifdef RETIRE_CNT_EN
    logic [RETIRE_CNT_W-1:0] retc;
`endif

    always #5 clk = ~clk;

    rob_head_ctrl #(.RENTRIES(N), .RSLOTS(S)) dut (
        .rst_i        (rst),
        .clk_i        (clk),
        .commit_i     (commit),
        .r_amt        (amt),
        .queued_i     (queued),
        .flush_i      (flush),
        .flush_tail_i (ft),
        .rob_heads    (heads),
        .rob_tails    (tails),
        .count_o      (cnt),
        .full_o       (full),
        .empty_o      (empty)
`ifdef RETIRE_CNT_EN
        ,
        .retired_cnt_o(retc)
`endif
    );

    typedef struct {
        int     head;
        int     tail;
        int     cnt;
        logic   full;
        logic   empty;
        longint retc;
    } exp_t;

    exp_t   sb [$];
    int     m_head, m_tail, m_cnt;
    longint m_ret;
    int     checks = 0;
    int     errors = 0;

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_cnt = 0; m_ret = 0;
        sb.delete();
    endtask

    // Drives one cycle of stimulus and pushes the model's expectation.
    task automatic drive(input logic c, input int a, input int q, input logic f, input int t);
        int   ret, acc, room;
        exp_t e;
        commit = c; amt = 4'(a); queued = 3'(q); flush = f; ft = rob_ptr_t'(t);
        ret    = c ? ((a < m_cnt) ? a : m_cnt) : 0;
        m_head = (m_head + ret) % N;
        m_ret  = m_ret + ret;
        if (f) begin
            m_tail = t % N;
            m_cnt  = ((t % N) - m_head + N) % N;
        end else begin
            room   = N - m_cnt + ret;
            acc    = (q < room) ? q : room;
            m_tail = (m_tail + acc) % N;
            m_cnt  = m_cnt + acc - ret;
        end
        e.head = m_head; e.tail = m_tail; e.cnt = m_cnt;
        e.full = (m_cnt > N - S); e.empty = (m_cnt == 0); e.retc = m_ret;
        sb.push_back(e);
        @(posedge clk); #1;
        commit = 1'b0; amt = '0; queued = '0; flush = 1'b0; ft = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic ok;
        rst = 1'b1; commit = 1'b1; amt = 4'd3; queued = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (heads[i] !== rob_ptr_t'(i)) ok = 1'b0;
        for (int i = 0; i < S; i++) if (tails[i] !== rob_ptr_t'(i)) ok = 1'b0;
        checks++;
        if (!ok || heads[0] !== 0 || heads[N-1] !== rob_ptr_t'(N-1)) begin
            errors++;
            $display("FAIL reset_ptrs: got head0=%0d headlast=%0d tail0=%0d, expected 0 %0d 0", heads[0], heads[N-1], tails[0], N-1);
        end
        checks++;
        if (cnt !== 0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got cnt=%0d empty=%b full=%b, expected 0 1 0", cnt, empty, full);
        end
        commit = 1'b0; amt = '0; queued = '0;
        rst = 1'b0;
        model_reset();
        // Idle cycle after release must hold reset state.
        drive(0, 0, 0, 0, 0);
        begin
            exp_t e = sb.pop_front();
            checks++;
            if (heads[0] !== rob_ptr_t'(e.head) || heads[N-1] !== rob_ptr_t'(N-1) || cnt !== 0 || empty !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle: got head0=%0d headlast=%0d cnt=%0d empty=%b, expected 0 %0d 0 1", heads[0], heads[N-1], cnt, empty, N-1);
            end
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            drive(0, 0, 4, 0, 0);
            e = sb.pop_front();
            checks++;
            if (cnt !== rob_cnt_t'(e.cnt) || full !== e.full || empty !== e.empty || tails[0] !== rob_ptr_t'(e.tail)) begin
                errors++;
                $display("FAIL fill step %0d: got cnt=%0d full=%b empty=%b tail=%0d, expected cnt=%0d full=%b empty=%b tail=%0d",
                         k, cnt, full, empty, tails[0], e.cnt, e.full, e.empty, e.tail);
            end
            if (k == 2) begin
                checks++;
                if (cnt !== 12 || tails[0] !== 12 || full !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_twelve: got cnt=%0d tail=%0d full=%b, expected 12 12 0", cnt, tails[0], full);
                end
            end
        end
        checks++;
        if (cnt !== 16 || full !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d full=%b empty=%b, expected 16 1 0", cnt, full, empty);
        end
    endtask

    task automatic test_retire_wrap();
        int c_t [3] = '{1, 0, 1};
        int a_t [3] = '{14, 0, 5};
        int q_t [3] = '{0, 4, 0};
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            logic ok;
            drive(c_t[k][0], a_t[k], q_t[k], 0, 0);
            e = sb.pop_front();
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (heads[i] !== rob_ptr_t'(e.head + i)) ok = 1'b0;
            for (int i = 0; i < S; i++) if (tails[i] !== rob_ptr_t'(e.tail + i)) ok = 1'b0;
            checks++;
            if (!ok || cnt !== rob_cnt_t'(e.cnt) || full !== e.full || empty !== e.empty) begin
                errors++;
                $display("FAIL retire_wrap step %0d: got head=%0d tail=%0d cnt=%0d, expected head=%0d tail=%0d cnt=%0d",
                         k, heads[0], tails[0], cnt, e.head, e.tail, e.cnt);
            end
        end
        checks++;
        if (heads[0] !== 3 || heads[N-1] !== 2 || cnt !== 1) begin
            errors++;
            $display("FAIL retire_wrap_final: got head0=%0d headlast=%0d cnt=%0d, expected 3 2 1", heads[0], heads[N-1], cnt);
        end
    endtask

    task automatic test_retire_clamp();
        exp_t e;
        drive(0, 0, 1, 0, 0);
        e = sb.pop_front();
        checks++;
        if (cnt !== rob_cnt_t'(e.cnt) || cnt !== 2) begin
            errors++;
            $display("FAIL clamp_setup: got cnt=%0d, expected 2", cnt);
        end
        drive(1, 7, 0, 0, 0);
        e = sb.pop_front();
        checks++;
        if (cnt !== 0 || empty !== 1'b1 || heads[0] !== rob_ptr_t'(e.head)) begin
            errors++;
            $display("FAIL clamp: got cnt=%0d empty=%b head=%0d, expected 0 1 %0d", cnt, empty, heads[0], e.head);
        end
`ifdef RETIRE_CNT_EN
        checks++;
        if (retc !== RETIRE_CNT_W'(e.retc)) begin
            errors++;
            $display("FAIL retired_total: got %0d, expected %0d", retc, e.retc);
        end
`endif
    endtask

    task automatic test_flush();
        int c_t [6] = '{0, 0, 0, 1, 1, 0};
        int a_t [6] = '{0, 0, 0, 4, 1, 0};
        int q_t [6] = '{4, 4, 4, 2, 3, 2};
        int f_t [6] = '{0, 0, 0, 0, 1, 1};
        int t_t [6] = '{0, 0, 0, 0, 7, 5};
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            drive(c_t[k][0], a_t[k], q_t[k], f_t[k][0], t_t[k]);
            e = sb.pop_front();
            checks++;
            if (heads[0] !== rob_ptr_t'(e.head) || tails[0] !== rob_ptr_t'(e.tail) || cnt !== rob_cnt_t'(e.cnt) ||
                full !== e.full || empty !== e.empty) begin
                errors++;
                $display("FAIL flush step %0d: got head=%0d tail=%0d cnt=%0d full=%b empty=%b, expected %0d %0d %0d %b %b",
                         k, heads[0], tails[0], cnt, full, empty, e.head, e.tail, e.cnt, e.full, e.empty);
            end
            if (k == 4) begin
                checks++;
                if (heads[0] !== 5 || tails[0] !== 7 || cnt !== 2) begin
                    errors++;
                    $display("FAIL flush_main: got head=%0d tail=%0d cnt=%0d, expected 5 7 2", heads[0], tails[0], cnt);
                end
            end
        end
        checks++;
        if (cnt !== 0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL flush_equal: got cnt=%0d empty=%b full=%b, expected 0 1 0", cnt, empty, full);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            exp_t e;
            logic ok;
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, S)),
                  ($urandom_range(0, 15) == 0), int'($urandom_range(0, N - 1)));
            e = sb.pop_front();
            ok = (cnt === rob_cnt_t'(e.cnt)) && (full === e.full) && (empty === e.empty);
            for (int i = 0; i < N; i++) if (heads[i] !== rob_ptr_t'(e.head + i)) ok = 1'b0;
            for (int i = 0; i < S; i++) if (tails[i] !== rob_ptr_t'(e.tail + i)) ok = 1'b0;
`ifdef RETIRE_CNT_EN
            if (retc !== RETIRE_CNT_W'(e.retc)) ok = 1'b0;
`endif
            checks++;
            if (!ok) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random cycle %0d: got head=%0d tail=%0d cnt=%0d full=%b empty=%b, expected %0d %0d %0d %b %b",
                             k, heads[0], tails[0], cnt, full, empty, e.head, e.tail, e.cnt, e.full, e.empty);
                bad++;
            end
        end
    endtask

    task automatic test_async_reset();
        commit = 1'b0; queued = 3'd3;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (cnt !== 0 || empty !== 1'b1 || heads[0] !== 0 || tails[0] !== 0 || heads[N-1] !== rob_ptr_t'(N-1)) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d empty=%b head=%0d tail=%0d, expected 0 1 0 0", cnt, empty, heads[0], tails[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (cnt !== 0 || tails[0] !== 0) begin
            errors++;
            $display("FAIL async_reset_hold: got cnt=%0d tail=%0d, expected 0 0", cnt, tails[0]);
        end
        queued = '0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_retire_wrap();
        test_retire_clamp();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
